mem_instr_sequencer: RTL and testbench
======================================

// Module: mem_instr_sequencer
// PURPOSE
//  Hardwired control FSM for ld, ldi and st. Drives the datapath control strobes (PCout, MARin, Read, MDRin,
//  Gra, BAout, Cout, Write, ...) for the full T0..T7 sequence of each instruction.
//  Sits between the top level and the datapath; replaces hand-timed bench stimulus with real control.
//  Generalised over opcode encoding, memory wait states and back-to-back fetch.
// PARAMETERS
//  OPC_W      5      opcode field width (IR[31:27])
//  OP_LD      5'd0   ld opcode:  R[ra] <- M[R[rb]+C]
//  OP_LDI     5'd1   ldi opcode: R[ra] <- R[rb]+C
//  OP_ST      5'd2   st opcode:  M[R[rb]+C] <- R[ra]
//  MEM_WAIT   0      extra cycles each memory step is held (0..15)
//  AUTO_FETCH 1      1: DONE goes straight to T0 while run=1; 0: always return to IDLE
// PORTS
//  Clock     in   1      rising-edge clock
//  Reset_n   in   1      asynchronous active-low reset
//  run       in   1      level; start/continue instruction execution
//  clr_fault in   1      one-cycle pulse; leaves FAULT
//  opcode    in   OPC_W  IR opcode field; sampled at end of T2 only
//  mem_ready in   1      memory completion (present only with SEQ_MEM_READY_EN)
//  ctrl      out  18     strobes: [0]PCout [1]MARin [2]IncPC [3]Zin [4]Read [5]MDRin [6]ZLOout [7]PCin
//                        [8]MDRout [9]IRin [10]Gra [11]Grb [12]BAout [13]Yin [14]Cout [15]Rout [16]Rin [17]Write
//  step      out  4      current T-step (0..7), 4'hF in IDLE or FAULT
//  busy      out  1      1 in any state other than IDLE or FAULT
//  done      out  1      1-cycle pulse in the last cycle of an instruction
//  fault     out  1      1 in FAULT
// BEHAVIOUR
//  - Reset: async to IDLE; ctrl=0, step=4'hF, busy=0, done=0, fault=0, wait counter=0.
//    Mid-instruction reset aborts immediately; strobes drop in the same instant.
//  - Moore outputs, decoded from the state register; each strobe held for the whole cycle.
//  - States: IDLE, T0..T7, FAULT.
//    IDLE -> T0 when run=1; otherwise stay.
//  - Common steps:
//    T0: PCout MARin IncPC Zin
//    T1(mem): Read MDRin every cycle; ZLOout PCin on the final cycle only (single PC update)
//    T2: MDRout IRin; decode opcode; no match -> FAULT
//  - Common address calculation:
//    T3: Grb BAout Yin
//    T4: Cout Zin
//  - ldi:
//    T5: ZLOout Gra Rin, done
//  - ld:
//    T5: ZLOout MARin
//    T6(mem): Read MDRin
//    T7: MDRout Gra Rin, done
//  - st:
//    T5: ZLOout MARin
//    T6: Gra Rout MDRin
//    T7(mem): Write held for all cycles, done on the final cycle
//  - Memory step length is MEM_WAIT+1 cycles, counted by a 4-bit counter; the counter clears on step entry.
//  - Latency from T0 entry (W=MEM_WAIT): ldi 6+W cycles; ld 8+2W; st 8+2W.
//  - After done: run=1 and AUTO_FETCH=1 -> T0 next cycle (no idle bubble). Otherwise -> IDLE.
//  - Dropping run mid-instruction does not abort; the instruction completes, then the FSM goes to IDLE.
//  - FAULT: all strobes 0, fault=1; left only by clr_fault (-> IDLE) or reset.
//    run is ignored while in FAULT.
//  - No two of {PCin, Rin, IRin, MARin, MDRin, Yin, Zin} target the bus value of different outputs in one cycle.
//    Exactly one bus driver ({PCout, ZLOout, MDRout, Rout, BAout, Cout}) is active per cycle, or none.
// CONFIGURATION
//  SEQ_MEM_READY_EN defined:
//    - Memory steps ignore MEM_WAIT and hold until mem_ready=1.
//    - The step ends in the cycle mem_ready is sampled high; single-cycle-step strobes (ZLOout/PCin, done) fire in that cycle.
//    - mem_ready high on step entry gives a one-cycle step.
//  Not defined:
//    - mem_ready port absent; fixed MEM_WAIT timing.
// TESTING
//  1 reset, run=0 for 5 cycles -> ctrl=0, step=F, busy=0 throughout
//  2 MEM_WAIT=0, opcode=2 (st), run pulsed 1 cycle
//    -> steps 0..7 in 8 cycles; Write only at T7; done at T7; then IDLE
//  3 MEM_WAIT=2, opcode=0 (ld)
//    -> T1 and T6 last 3 cycles each; PCin exactly once; done at cycle 12 after T0 entry
//  4 opcode=1 (ldi), run held 1, AUTO_FETCH=1 -> done at T5, step=0 on the next cycle, two instructions back to back
//  5 opcode=5'd9 -> FAULT after T2, fault=1, ctrl=0; clr_fault -> IDLE
//  6 Reset_n low at T6 of st -> Write and all outputs 0 asynchronously; run=1 after release -> restarts at T0

Source files
------------

// File: rtl/mem_instr_sequencer.sv
// Hardwired T0..T7 control sequencer for ld, ldi and st; Moore strobes are decoded from the state register.
// Optional SEQ_MEM_READY_EN: memory steps end on mem_ready instead of after the fixed MEM_WAIT count.
module mem_instr_sequencer #(
  parameter int               OPC_W      = 5,
  parameter logic [OPC_W-1:0] OP_LD      = OPC_W'(0),
  parameter logic [OPC_W-1:0] OP_LDI     = OPC_W'(1),
  parameter logic [OPC_W-1:0] OP_ST      = OPC_W'(2),
  parameter int unsigned      MEM_WAIT   = 0,
  parameter bit               AUTO_FETCH = 1'b1
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             run,
  input  logic             clr_fault,
`ifdef SEQ_MEM_READY_EN
  input  logic             mem_ready,
`endif
  input  logic [OPC_W-1:0] opcode,
  output logic [17:0]      ctrl,
  output logic [3:0]       step,
  output logic             busy,
  output logic             done,
  output logic             fault
);

  localparam int B_PCOUT  = 0;
  localparam int B_MARIN  = 1;
  localparam int B_INCPC  = 2;
  localparam int B_ZIN    = 3;
  localparam int B_READ   = 4;
  localparam int B_MDRIN  = 5;
  localparam int B_ZLOOUT = 6;
  localparam int B_PCIN   = 7;
  localparam int B_MDROUT = 8;
  localparam int B_IRIN   = 9;
  localparam int B_GRA    = 10;
  localparam int B_GRB    = 11;
  localparam int B_BAOUT  = 12;
  localparam int B_YIN    = 13;
  localparam int B_COUT   = 14;
  localparam int B_ROUT   = 15;
  localparam int B_RIN    = 16;
  localparam int B_WRITE  = 17;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_FAULT
  } state_t;

  typedef enum logic [1:0] {I_LD, I_LDI, I_ST} instr_t;

  state_t     state_q, state_d;
  instr_t     instr_q, instr_d;
  logic       opc_ok;
  logic [3:0] wait_cnt;
  logic       mem_step;
  logic       step_last;

  // Steps that touch memory and may therefore be stretched.
  assign mem_step = (state_q == S_T1) ||
                    (state_q == S_T6 && instr_q == I_LD) ||
                    (state_q == S_T7 && instr_q == I_ST);

`ifdef SEQ_MEM_READY_EN
  assign step_last = mem_ready;
`else
  assign step_last = (wait_cnt == 4'(MEM_WAIT));
`endif

  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      instr_q  <= I_LD;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_T2) instr_q <= instr_d;
      if (state_d != state_q)
        wait_cnt <= '0;
      else if (mem_step)
        wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d = state_q;
    instr_d = instr_q;
    opc_ok  = 1'b1;
    ctrl    = '0;
    step    = 4'hF;
    busy    = 1'b1;
    done    = 1'b0;
    fault   = 1'b0;

    if (opcode == OP_LD)       instr_d = I_LD;
    else if (opcode == OP_LDI) instr_d = I_LDI;
    else if (opcode == OP_ST)  instr_d = I_ST;
    else                       opc_ok  = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (run) state_d = S_T0;
      end
      S_T0: begin
        step = 4'd0;
        ctrl[B_PCOUT] = 1'b1;
        ctrl[B_MARIN] = 1'b1;
        ctrl[B_INCPC] = 1'b1;
        ctrl[B_ZIN]   = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        step = 4'd1;
        ctrl[B_READ]  = 1'b1;
        ctrl[B_MDRIN] = 1'b1;
        // PC is written back once, in the closing cycle of the fetch read.
        if (step_last) begin
          ctrl[B_ZLOOUT] = 1'b1;
          ctrl[B_PCIN]   = 1'b1;
          state_d = S_T2;
        end
      end
      S_T2: begin
        step = 4'd2;
        ctrl[B_MDROUT] = 1'b1;
        ctrl[B_IRIN]   = 1'b1;
        state_d = opc_ok ? S_T3 : S_FAULT;
      end
      S_T3: begin
        step = 4'd3;
        ctrl[B_GRB]   = 1'b1;
        ctrl[B_BAOUT] = 1'b1;
        ctrl[B_YIN]   = 1'b1;
        state_d = S_T4;
      end
      S_T4: begin
        step = 4'd4;
        ctrl[B_COUT] = 1'b1;
        ctrl[B_ZIN]  = 1'b1;
        state_d = S_T5;
      end
      S_T5: begin
        step = 4'd5;
        ctrl[B_ZLOOUT] = 1'b1;
        if (instr_q == I_LDI) begin
          ctrl[B_GRA] = 1'b1;
          ctrl[B_RIN] = 1'b1;
          done    = 1'b1;
          state_d = (run && AUTO_FETCH) ? S_T0 : S_IDLE;
        end else begin
          ctrl[B_MARIN] = 1'b1;
          state_d = S_T6;
        end
      end
      S_T6: begin
        step = 4'd6;
        ctrl[B_MDRIN] = 1'b1;
        if (instr_q == I_LD) begin
          ctrl[B_READ] = 1'b1;
          if (step_last) state_d = S_T7;
        end else begin
          ctrl[B_GRA]  = 1'b1;
          ctrl[B_ROUT] = 1'b1;
          state_d = S_T7;
        end
      end
      S_T7: begin
        step = 4'd7;
        if (instr_q == I_LD) begin
          ctrl[B_MDROUT] = 1'b1;
          ctrl[B_GRA]    = 1'b1;
          ctrl[B_RIN]    = 1'b1;
          done    = 1'b1;
          state_d = (run && AUTO_FETCH) ? S_T0 : S_IDLE;
        end else begin
          ctrl[B_WRITE] = 1'b1;
          if (step_last) begin
            done    = 1'b1;
            state_d = (run && AUTO_FETCH) ? S_T0 : S_IDLE;
          end
        end
      end
      S_FAULT: begin
        busy  = 1'b0;
        fault = 1'b1;
        if (clr_fault) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_instr_sequencer.sv
// Self-checking bench for mem_instr_sequencer: two instances (MEM_WAIT 0 and 2) checked cycle by cycle
// against per-instruction expected traces built from the instruction step tables.
module tb_mem_instr_sequencer;

  localparam int W0 = 0;
`ifdef SEQ_MEM_READY_EN
  localparam int W1 = 0;
`else
  localparam int W1 = 2;
`endif

  localparam logic [17:0] M_PCOUT  = 18'd1 << 0;
  localparam logic [17:0] M_MARIN  = 18'd1 << 1;
  localparam logic [17:0] M_INCPC  = 18'd1 << 2;
  localparam logic [17:0] M_ZIN    = 18'd1 << 3;
  localparam logic [17:0] M_READ   = 18'd1 << 4;
  localparam logic [17:0] M_MDRIN  = 18'd1 << 5;
  localparam logic [17:0] M_ZLOOUT = 18'd1 << 6;
  localparam logic [17:0] M_PCIN   = 18'd1 << 7;
  localparam logic [17:0] M_MDROUT = 18'd1 << 8;
  localparam logic [17:0] M_IRIN   = 18'd1 << 9;
  localparam logic [17:0] M_GRA    = 18'd1 << 10;
  localparam logic [17:0] M_GRB    = 18'd1 << 11;
  localparam logic [17:0] M_BAOUT  = 18'd1 << 12;
  localparam logic [17:0] M_YIN    = 18'd1 << 13;
  localparam logic [17:0] M_COUT   = 18'd1 << 14;
  localparam logic [17:0] M_ROUT   = 18'd1 << 15;
  localparam logic [17:0] M_RIN    = 18'd1 << 16;
  localparam logic [17:0] M_WRITE  = 18'd1 << 17;

  typedef struct packed {
    logic [3:0]  step;
    logic [17:0] ctrl;
    logic        busy;
    logic        done;
    logic        fault;
  } obs_t;

  typedef enum int {K_LD, K_LDI, K_ST, K_BAD} kind_e;

  localparam obs_t IDLE_OBS  = {4'hF, 18'd0, 1'b0, 1'b0, 1'b0};
  localparam obs_t FAULT_OBS = {4'hF, 18'd0, 1'b0, 1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_i [2];
  logic        clr_i [2];
  logic [4:0]  opc_i [2];
  logic [17:0] ctrl_o [2];
  logic [3:0]  step_o [2];
  logic        busy_o [2];
  logic        done_o [2];
  logic        fault_o [2];

  obs_t exp_q[$];
  int   drv_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_instr_sequencer #(.MEM_WAIT(W0), .AUTO_FETCH(1'b1)) u_dut0 (
    .Clock(clk), .Reset_n(rst_n), .run(run_i[0]), .clr_fault(clr_i[0]),
`ifdef SEQ_MEM_READY_EN
    .mem_ready(1'b1),
`endif
    .opcode(opc_i[0]), .ctrl(ctrl_o[0]), .step(step_o[0]), .busy(busy_o[0]),
    .done(done_o[0]), .fault(fault_o[0])
  );

  mem_instr_sequencer #(.MEM_WAIT(W1), .AUTO_FETCH(1'b1)) u_dut1 (
    .Clock(clk), .Reset_n(rst_n), .run(run_i[1]), .clr_fault(clr_i[1]),
`ifdef SEQ_MEM_READY_EN
    .mem_ready(1'b1),
`endif
    .opcode(opc_i[1]), .ctrl(ctrl_o[1]), .step(step_o[1]), .busy(busy_o[1]),
    .done(done_o[1]), .fault(fault_o[1])
  );

  function automatic int wof(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  function automatic obs_t get_obs(input int d);
    return {step_o[d], ctrl_o[d], busy_o[d], done_o[d], fault_o[d]};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("step=%h ctrl=%05h busy=%b done=%b fault=%b", o.step, o.ctrl, o.busy, o.done, o.fault);
  endfunction

  function automatic obs_t mk(input int s, input logic [17:0] c, input bit dn);
    return {4'(s), c, 1'b1, dn, 1'b0};
  endfunction

  function automatic void push(input int s, input logic [17:0] c, input bit dn, input int drv);
    exp_q.push_back(mk(s, c, dn));
    drv_q.push_back(drv);
  endfunction

  // Expected trace of one instruction from T0 entry; drv_q holds the opcode to present during T2.
  function automatic void add_instr(input kind_e k, input int w, input logic [4:0] opc);
    push(0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 1'b0, -1);
    for (int i = 0; i <= w; i++)
      push(1, M_READ | M_MDRIN | ((i == w) ? (M_ZLOOUT | M_PCIN) : 18'd0), 1'b0, -1);
    push(2, M_MDROUT | M_IRIN, 1'b0, int'(opc));
    if (k == K_BAD) return;
    push(3, M_GRB | M_BAOUT | M_YIN, 1'b0, -1);
    push(4, M_COUT | M_ZIN, 1'b0, -1);
    if (k == K_LDI) begin
      push(5, M_ZLOOUT | M_GRA | M_RIN, 1'b1, -1);
    end else if (k == K_LD) begin
      push(5, M_ZLOOUT | M_MARIN, 1'b0, -1);
      for (int i = 0; i <= w; i++) push(6, M_READ | M_MDRIN, 1'b0, -1);
      push(7, M_MDROUT | M_GRA | M_RIN, 1'b1, -1);
    end else begin
      push(5, M_ZLOOUT | M_MARIN, 1'b0, -1);
      push(6, M_GRA | M_ROUT | M_MDRIN, 1'b0, -1);
      for (int i = 0; i <= w; i++) push(7, M_WRITE, (i == w), -1);
    end
  endfunction

  function automatic logic [4:0] opc_of(input kind_e k);
    case (k)
      K_LD:    return 5'd0;
      K_LDI:   return 5'd1;
      K_ST:    return 5'd2;
      default: return 5'($urandom_range(3, 31));
    endcase
  endfunction

  // Plays the queued trace on one instance: run raised now, compared at each falling edge.
  task automatic play(input int d, input bit hold, input int ncyc, input string name,
                      output int pcin_n, output int done_at);
    int   lim;
    obs_t o;
    lim = (ncyc < 0 || ncyc > exp_q.size()) ? exp_q.size() : ncyc;
    pcin_n  = 0;
    done_at = -1;
    run_i[d] = 1'b1;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      o = get_obs(d);
      if ((o.ctrl & M_PCIN) != 18'd0) pcin_n++;
      if (o.done === 1'b1 && done_at < 0) done_at = k;
      n_cmp++;
      if (o !== exp_q[k]) begin
        n_err++;
        $display("FAIL %s dut%0d cyc %0d: got %s, want %s", name, d, k, fmt(o), fmt(exp_q[k]));
      end
      opc_i[d] = (drv_q[k] >= 0) ? 5'(drv_q[k]) : 5'($urandom);
      clr_i[d] = 1'($urandom);
      run_i[d] = (k == exp_q.size() - 1) ? 1'b0 : (hold ? 1'b1 : 1'($urandom));
    end
    exp_q.delete();
    drv_q.delete();
  endtask

  task automatic expect_idle(input int d, input string name);
    obs_t o;
    @(negedge clk);
    o = get_obs(d);
    n_cmp++;
    if (o !== IDLE_OBS) begin
      n_err++;
      $display("FAIL %s dut%0d: got %s, want %s", name, d, fmt(o), fmt(IDLE_OBS));
    end
  endtask

  task automatic test_reset();
    obs_t o;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      run_i[d] = 1'b0; clr_i[d] = 1'b0; opc_i[d] = 5'd0;
    end
    #3;
    for (int d = 0; d < 2; d++) begin
      o = get_obs(d);
      n_cmp++;
      if (o !== IDLE_OBS) begin
        n_err++;
        $display("FAIL reset_in dut%0d: got %s, want %s", d, fmt(o), fmt(IDLE_OBS));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) for (int d = 0; d < 2; d++) expect_idle(d, "reset_idle");
  endtask

  task automatic test_st_single();
    int p, da;
    add_instr(K_ST, W0, opc_of(K_ST));
    play(0, 1'b0, -1, "st_single", p, da);
    n_cmp++;
    if (da !== 8 + 2 * W0 - 1) begin
      n_err++;
      $display("FAIL st_done_cycle: got %0d, want %0d", da, 8 + 2 * W0 - 1);
    end
    expect_idle(0, "st_after");
  endtask

  task automatic test_ld_wait();
    int p, da;
    add_instr(K_LD, W1, opc_of(K_LD));
    play(1, 1'b0, -1, "ld_wait", p, da);
    n_cmp++;
    if (p !== 1) begin
      n_err++;
      $display("FAIL ld_pcin_count: got %0d, want 1", p);
    end
    n_cmp++;
    if (da !== 8 + 2 * W1 - 1) begin
      n_err++;
      $display("FAIL ld_done_cycle: got %0d, want %0d", da, 8 + 2 * W1 - 1);
    end
    expect_idle(1, "ld_after");
  endtask

  task automatic test_back_to_back();
    int p, da;
    for (int d = 0; d < 2; d++) begin
      add_instr(K_LDI, wof(d), opc_of(K_LDI));
      add_instr(K_LDI, wof(d), opc_of(K_LDI));
      play(d, 1'b1, -1, "ldi_b2b", p, da);
      n_cmp++;
      if (p !== 2) begin
        n_err++;
        $display("FAIL b2b_pcin_count dut%0d: got %0d, want 2", d, p);
      end
      expect_idle(d, "b2b_after");
    end
  endtask

  task automatic test_fault();
    int   p, da;
    obs_t o;
    for (int d = 0; d < 2; d++) begin
      add_instr(K_BAD, wof(d), (d == 0) ? 5'd9 : opc_of(K_BAD));
      play(d, 1'b0, -1, "bad_fetch", p, da);
      repeat (4) begin
        @(negedge clk);
        o = get_obs(d);
        n_cmp++;
        if (o !== FAULT_OBS) begin
          n_err++;
          $display("FAIL fault_hold dut%0d: got %s, want %s", d, fmt(o), fmt(FAULT_OBS));
        end
        clr_i[d] = 1'b0;
        run_i[d] = 1'($urandom);
      end
      clr_i[d] = 1'b1;
      run_i[d] = 1'b0;
      expect_idle(d, "fault_clear");
      clr_i[d] = 1'b0;
      expect_idle(d, "fault_clear_stay");
    end
  endtask

  task automatic test_reset_mid();
    int   p, da;
    obs_t o;
    for (int d = 0; d < 2; d++) begin
      // dut0 is reset in T6, dut1 in the first T7 cycle while Write is high.
      add_instr(K_ST, wof(d), opc_of(K_ST));
      play(d, 1'b1, wof(d) + 7 + d, "st_abort", p, da);
      #2;
      rst_n = 1'b0;
      #1;
      o = get_obs(d);
      n_cmp++;
      if (o !== IDLE_OBS) begin
        n_err++;
        $display("FAIL async_reset dut%0d: got %s, want %s", d, fmt(o), fmt(IDLE_OBS));
      end
      @(negedge clk);
      rst_n = 1'b1;
      add_instr(K_LDI, wof(d), opc_of(K_LDI));
      play(d, 1'b0, -1, "restart", p, da);
      expect_idle(d, "restart_after");
    end
  endtask

  task automatic test_random();
    int    p, da, d, n;
    kind_e k;
    for (int it = 0; it < 12; it++) begin
      d = $urandom_range(0, 1);
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) begin
        k = kind_e'($urandom_range(0, 2));
        add_instr(k, wof(d), opc_of(k));
      end
      play(d, (n > 1), -1, "random", p, da);
      n_cmp++;
      if (p !== n) begin
        n_err++;
        $display("FAIL random_pcin_count dut%0d: got %0d, want %0d", d, p, n);
      end
      expect_idle(d, "random_after");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_st_single();
    test_ld_wait();
    test_back_to_back();
    test_fault();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
